// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (shift-and-add-3); BIN2BCD_SIGNED_EN selects two's-complement input.
// Latency: DONE pulses 10 cycles after START is accepted; one conversion every 11 cycles back-to-back.
// Backpressure: none; START is only sampled while idle, and requests that arrive while busy are dropped.
module bin2bcd_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [8:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o,
    output logic        sign_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic        sign_cap_q, sign_cap_d;
    logic [11:0] bcd_q, bcd_d;
    logic        sign_q, sign_d;
    logic        done_q, done_d;

    logic [8:0]  mag;
    logic        sign_in;
    logic [11:0] adj;

`ifdef BIN2BCD_SIGNED_EN
    // 9'h100 negates to itself, which reads correctly as magnitude 256.
    assign sign_in = bin_i[8];
    assign mag     = bin_i[8] ? (~bin_i + 9'd1) : bin_i;
`else
    assign sign_in = 1'b0;
    assign mag     = bin_i;
`endif

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        sign_cap_d = sign_cap_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shift_d    = mag;
                    scratch_d  = 12'h000;
                    cnt_d      = 4'd9;
                    sign_cap_d = sign_in;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_d, shift_d} = {adj[10:0], shift_q, 1'b0};
                cnt_d                = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                bcd_d   = scratch_q;
                sign_d  = sign_cap_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 9'd0;
            scratch_q  <= 12'h000;
            sign_cap_q <= 1'b0;
            bcd_q      <= 12'h000;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            sign_cap_q <= sign_cap_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
        end
    end

    assign busy_o = (state_q == S_SHIFT) || (state_q == S_FIN);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign sign_o = sign_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameters: none; widths fixed (9-bit binary in, 3 BCD digits out).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  conversion request; sampled only while idle.
REQ-005 BIN  input  9  value to convert; sampled on the START-accept edge only.
REQ-006 BUSY  output  1  high while a conversion is in progress.
REQ-007 DONE  output  1  one-cycle pulse; BCD/SIGN updated on the same edge.
REQ-008 BCD  output  12  result digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 SIGN  output  1  result negative (drives the display sign digit).

Function
REQ-010 FSM states: IDLE, SHIFT, FIN; unused encodings SHALL return to IDLE on next edge.
REQ-011 IDLE with START=1 at edge E0: capture magnitude of BIN into 9-bit shift reg, clear 12-bit scratch BCD, load iteration counter = 9, go SHIFT.
REQ-012 SHIFT, each edge: every scratch digit >= 5 gets +3, then {scratch, shift reg} shifted left 1; counter decrements.
REQ-013 Counter reaches 0 (edge E9, ninth shift): go FIN.
REQ-014 FIN (edge E10): copy scratch to BCD and captured sign to SIGN, DONE=1 for the following cycle, go IDLE.
REQ-015 Latency: DONE high exactly in the cycle after E10, i.e. 10 cycles after START accepted.
REQ-016 BUSY=1 in every cycle after E0 up to and including the cycle after E9; BUSY=0 in the DONE cycle.
REQ-017 START while BUSY=1 SHALL be ignored (not queued); BIN changes while busy SHALL not affect the result.
REQ-018 START high in the DONE cycle SHALL be accepted (back-to-back throughput 11 cycles).
REQ-019 BCD/SIGN SHALL hold the previous result unchanged through a conversion; only the FIN edge updates them (glitch-free for the display mux).
REQ-020 Every output digit SHALL be 0-9; maximum magnitude 511 fits 3 digits, no overflow output.
REQ-021 START held high continuously SHALL restart a conversion on each DONE cycle.

Reset
REQ-022 RST=1 at an edge: state IDLE, counter 0, scratch 0, BCD=12'h000, SIGN=0, BUSY=0, DONE=0.
REQ-023 RST asserted mid-conversion SHALL abort it with no DONE pulse and no BCD/SIGN update.
REQ-024 RST has priority over START on the same edge.

Configuration
REQ-025 Macro BIN2BCD_SIGNED_EN defined: BIN is two's complement (-256..255); magnitude = |BIN| (9'h100 -> 256); SIGN = BIN[8] at capture.
REQ-026 BIN2BCD_SIGNED_EN undefined: BIN unsigned (0..511); magnitude = BIN; SIGN constant 0.

Verification
REQ-027 Signed build, BIN=9'd255, START 1 cycle -> DONE 10 cycles later, BCD=12'h255, SIGN=0; BUSY high 10 cycles.
REQ-028 Signed build, BIN=9'h100 -> BCD=12'h256, SIGN=1; BIN=9'h1FF -> BCD=12'h001, SIGN=1; BIN=0 -> 12'h000, SIGN=0.
REQ-029 Unsigned build, BIN=9'h1FF -> BCD=12'h511, SIGN=0; BIN=9'd100 -> 12'h100.
REQ-030 Convert 37, then pulse START with BIN=99 at cycle 4 of busy -> ignored; single DONE with 12'h037; BIN changes mid-conversion have no effect.
REQ-031 Convert 123 (BCD=12'h123), start 45, assert RST at cycle 5 -> no DONE, BCD=12'h000, BUSY=0 next cycle; new START then converts normally.
REQ-032 Exhaustive: all 512 BIN values, START re-asserted in each DONE cycle -> every result matches reference magnitude/sign, DONE every 11 cycles.
